// File: rtl/bus_arbiter_decoder.sv
// Round-robin arbiter for N_MASTERS requesters onto one peripheral register bus, with region decode.
// Optional ISSUE timeout when BUS_ARBITER_TIMEOUT_EN is defined.
module bus_arbiter_decoder #(
    parameter int unsigned N_MASTERS      = 2,
    parameter int unsigned N_REGIONS      = 3,
    parameter logic [31:0] BASE_ADDR      = 32'h43c00000,
    parameter logic [31:0] REGION_SIZE    = 32'h1000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_MASTERS-1:0]      m_valid,
    input  logic [N_MASTERS-1:0]      m_we,
    input  logic [32*N_MASTERS-1:0]   m_addr,
    input  logic [32*N_MASTERS-1:0]   m_wdata,
    output logic [N_MASTERS-1:0]      m_ready,
    output logic [N_MASTERS-1:0]      m_resp_valid,
    output logic [31:0]               m_resp_data,
    output logic                      m_resp_err,
    output logic                      s_valid,
    output logic [N_REGIONS-1:0]      s_sel,
    output logic                      s_we,
    output logic [31:0]               s_addr,
    output logic [31:0]               s_wdata,
    input  logic                      s_ack,
    input  logic [31:0]               s_rdata
);

    localparam int unsigned GW  = $clog2(N_MASTERS);
    localparam int unsigned RSH = $clog2(REGION_SIZE);

    if (N_MASTERS < 2 || N_MASTERS > 8 || N_REGIONS < 1 ||
        (REGION_SIZE & (REGION_SIZE - 32'd1)) != 32'd0 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("bus_arbiter_decoder: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t               state, state_n;
    logic [GW-1:0]        last_grant, grant_q, winner, cand;
    logic                 found;
    logic [31:0]          win_addr, off, idx;
    logic                 in_range;
    logic [N_REGIONS-1:0] dec_sel, sel_q;
    logic [31:0]          addr_q, wdata_q, data_q;
    logic                 we_q, err_q;
    logic                 timeout_hit;

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt;

    // cnt holds the number of completed ISSUE cycles; the current one makes TIMEOUT_CYCLES
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || state != ISSUE) cnt <= '0;
        else if (!s_ack)             cnt <= cnt + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Search upward from last_grant+1, wrapping modulo N_MASTERS.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned k = 1; k <= N_MASTERS; k++) begin
            cand = GW'((32'(last_grant) + k) % N_MASTERS);
            if (!found && m_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign win_addr = m_addr[32*winner +: 32];
    assign off      = win_addr - BASE_ADDR;
    assign idx      = off >> RSH;
    assign in_range = (win_addr >= BASE_ADDR) && (idx < N_REGIONS);

    always_comb begin
        dec_sel = '0;
        for (int unsigned r = 0; r < N_REGIONS; r++) dec_sel[r] = (idx == r);
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n      = state;
        m_ready      = '0;
        m_resp_valid = '0;
        m_resp_data  = '0;
        m_resp_err   = 1'b0;
        s_valid      = 1'b0;
        s_sel        = '0;
        s_we         = 1'b0;
        s_addr       = '0;
        s_wdata      = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    m_ready[winner] = 1'b1;
                    state_n         = in_range ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                s_valid = 1'b1;
                s_sel   = sel_q;
                s_we    = we_q;
                s_addr  = addr_q;
                s_wdata = wdata_q;
                if (s_ack || timeout_hit) state_n = RESP;
            end
            RESP: begin
                m_resp_valid[grant_q] = 1'b1;
                m_resp_data           = data_q;
                m_resp_err            = err_q;
                state_n               = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= GW'(N_MASTERS - 1);
            grant_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_q <= winner;
                        addr_q  <= win_addr;
                        wdata_q <= m_wdata[32*winner +: 32];
                        we_q    <= m_we[winner];
                        sel_q   <= dec_sel;
                        data_q  <= '0;
                        err_q   <= !in_range;
                    end
                end
                ISSUE: begin
                    if (s_ack) begin
                        data_q <= we_q ? '0 : s_rdata;
                        err_q  <= 1'b0;
                    end else if (timeout_hit) begin
                        data_q <= '0;
                        err_q  <= 1'b1;
                    end
                end
                RESP: last_grant <= grant_q;
                default: ;
            endcase
        end
    end

endmodule
